leiwand_rv32_core: RTL and testbench

// - Multi-cycle, non-pipelined RV32I CPU core; one 32-bit valid/ready memory bus shared by fetch and load/store.
// - Sits in the SoC beside the word RAM simple_mem (0x20400000 base) and drives one debug LED.
// - Each instruction steps FETCH -> DECODE -> ALU_PREPARE -> EXECUTE -> MEM -> WRITEBACK.

---
 rtl/leiwand_rv32_core_pkg.sv | 52 +++++
 rtl/simple_mem.sv | 39 +++
 rtl/leiwand_rv32_core.sv | 204 ++++++++++++++++++++
 tb/tb_leiwand_rv32_core.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/leiwand_rv32_core_pkg.sv
// rtl/leiwand_rv32_core_pkg.sv - shared constants, opcodes and stage codes for the leiwand RV32I core
package leiwand_rv32_constants;
    localparam int MEM_WIDTH  = 32;
    localparam int NR_RV_REGS = 32;

    localparam logic [31:0] RESET_PC = 32'h2040_0000;
    localparam logic [31:0] LED_ADDR = 32'h1001_2000;

    typedef enum logic [2:0] {
        STAGE_INSTR_FETCH = 3'd0,
        STAGE_DECODE      = 3'd1,
        STAGE_ALU_PREPARE = 3'd2,
        STAGE_EXECUTE     = 3'd3,
        STAGE_MEM         = 3'd4,
        STAGE_WRITEBACK   = 3'd5
    } cpu_stage_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALU funct3
    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    // branch funct3
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    // load/store width funct3
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
endpackage

// File: rtl/simple_mem.sv
// rtl/simple_mem.sv - word RAM with registered ready and byte write enables
module simple_mem #(
    parameter int WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    output logic        ready,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(WORDS);

    logic [31:0]   mem [0:WORDS-1];
    logic [AW-1:0] idx;
    logic          unused_addr_bits;

    // base address bits above the array and byte offset are don't-care
    assign idx              = addr[AW+1:2];
    assign rdata            = mem[idx];
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

    // ready answers one cycle after a request and falls with valid
    always_ff @(posedge clk) begin
        if (rst) ready <= 1'b0;
        else     ready <= valid;
    end

    // byte-lane writes while a request with write enables is present
    always_ff @(posedge clk) begin
        if (valid) begin
            for (int b = 0; b < 4; b++) begin
                if (wen[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: rtl/leiwand_rv32_core.sv
// rtl/leiwand_rv32_core.sv - multi-cycle non-pipelined RV32I core with a shared valid/ready bus
module leiwand_rv32_core
    import leiwand_rv32_constants::*;
#(
    parameter logic [31:0] RESET_PC = leiwand_rv32_constants::RESET_PC,
    parameter logic [31:0] LED_ADDR = leiwand_rv32_constants::LED_ADDR
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [MEM_WIDTH-1:0] mem_addr,
    input  logic [MEM_WIDTH-1:0] mem_data_cpu_in,
    output logic [MEM_WIDTH-1:0] mem_data_cpu_out,
    output logic [3:0]           mem_wen,
    output logic                 debug_led
);
    cpu_stage_t  cpu_stage, next_stage;
    logic [31:0] pc, instruction;
    logic [31:0] x [0:NR_RV_REGS-1];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [31:0] imm, op_a, op_b, alu_result, ea, load_result;
    logic        branch_taken;

    logic [31:0] alu_b, alu_comb, load_comb, store_data, rd_value;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [3:0]  store_wen;
    logic        cmp_comb, is_load, is_store, led_store, writes_rd;

    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign led_store = is_store && (ea == LED_ADDR);
    assign writes_rd = (opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL) ||
                       (opcode == OPC_JALR) || is_load || (opcode == OPC_OP) || (opcode == OPC_OP_IMM);

    // stage register
    always_ff @(posedge clk) begin
        if (reset) cpu_stage <= STAGE_INSTR_FETCH;
        else       cpu_stage <= next_stage;
    end

    // stage sequencing; bus stages wait for mem_ready on their own request
    always_comb begin
        next_stage = cpu_stage;
        case (cpu_stage)
            STAGE_INSTR_FETCH: if (mem_valid && mem_ready) next_stage = STAGE_DECODE;
            STAGE_DECODE:      next_stage = STAGE_ALU_PREPARE;
            STAGE_ALU_PREPARE: next_stage = STAGE_EXECUTE;
            STAGE_EXECUTE:     next_stage = (is_load || is_store) ? STAGE_MEM : STAGE_WRITEBACK;
            STAGE_MEM:         if (led_store || (mem_valid && mem_ready)) next_stage = STAGE_WRITEBACK;
            STAGE_WRITEBACK:   next_stage = STAGE_INSTR_FETCH;
            default:           next_stage = STAGE_INSTR_FETCH;
        endcase
    end

    // ALU and branch comparator; SUB only exists in the register-register form
    always_comb begin
        alu_b    = (opcode == OPC_OP) ? op_b : imm;
        alu_comb = 32'd0;
        cmp_comb = 1'b0;
        case (funct3)
            F3_ADD:  alu_comb = ((opcode == OPC_OP) && funct7_b5) ? op_a - alu_b : op_a + alu_b;
            F3_SLL:  alu_comb = op_a << alu_b[4:0];
            F3_SLT:  alu_comb = {31'd0, $signed(op_a) < $signed(alu_b)};
            F3_SLTU: alu_comb = {31'd0, op_a < alu_b};
            F3_XOR:  alu_comb = op_a ^ alu_b;
            F3_SR:   alu_comb = funct7_b5 ? 32'($signed(op_a) >>> alu_b[4:0]) : op_a >> alu_b[4:0];
            F3_OR:   alu_comb = op_a | alu_b;
            F3_AND:  alu_comb = op_a & alu_b;
            default: alu_comb = 32'd0;
        endcase
        case (funct3)
            F3_BEQ:  cmp_comb = (op_a == op_b);
            F3_BNE:  cmp_comb = (op_a != op_b);
            F3_BLT:  cmp_comb = ($signed(op_a) < $signed(op_b));
            F3_BGE:  cmp_comb = ($signed(op_a) >= $signed(op_b));
            F3_BLTU: cmp_comb = (op_a < op_b);
            F3_BGEU: cmp_comb = (op_a >= op_b);
            default: cmp_comb = 1'b0;
        endcase
    end

    // byte-lane steering for stores and lane selection/extension for loads
    always_comb begin
        store_wen  = 4'b1111;
        store_data = op_b;
        case (funct3)
            F3_B: begin
                store_wen  = 4'b0001 << ea[1:0];
                store_data = {4{op_b[7:0]}};
            end
            F3_H: begin
                store_wen  = 4'b0011 << {ea[1], 1'b0};
                store_data = {2{op_b[15:0]}};
            end
            default: store_wen = 4'b1111;
        endcase
        load_byte = mem_data_cpu_in[{ea[1:0], 3'b000} +: 8];
        load_half = ea[1] ? mem_data_cpu_in[31:16] : mem_data_cpu_in[15:0];
        case (funct3)
            F3_B:    load_comb = {{24{load_byte[7]}}, load_byte};
            F3_H:    load_comb = {{16{load_half[15]}}, load_half};
            F3_BU:   load_comb = {24'd0, load_byte};
            F3_HU:   load_comb = {16'd0, load_half};
            default: load_comb = mem_data_cpu_in;
        endcase
    end

    // value written to rd; pc here is still the address of the retiring instruction
    always_comb begin
        case (opcode)
            OPC_LUI:            rd_value = imm;
            OPC_AUIPC:          rd_value = pc + imm;
            OPC_JAL, OPC_JALR:  rd_value = pc + 32'd4;
            OPC_LOAD:           rd_value = load_result;
            default:            rd_value = alu_result;
        endcase
    end

    // datapath, register file and bus request registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc               <= RESET_PC;
            instruction      <= 32'd0;
            mem_valid        <= 1'b0;
            mem_wen          <= 4'b0000;
            mem_addr         <= 32'd0;
            mem_data_cpu_out <= 32'd0;
            debug_led        <= 1'b0;
            opcode <= 7'd0; rd <= 5'd0; rs1 <= 5'd0; rs2 <= 5'd0; funct3 <= 3'd0; funct7_b5 <= 1'b0;
            imm <= 32'd0; op_a <= 32'd0; op_b <= 32'd0;
            alu_result <= 32'd0; ea <= 32'd0; load_result <= 32'd0; branch_taken <= 1'b0;
            for (int i = 0; i < NR_RV_REGS; i++) x[i] <= 32'd0;
        end else begin
            case (cpu_stage)
                STAGE_INSTR_FETCH: begin
                    if (!mem_valid) begin
                        mem_valid <= 1'b1;
                        mem_addr  <= pc;
                        mem_wen   <= 4'b0000;
                    end else if (mem_ready) begin
                        instruction <= mem_data_cpu_in;
                        mem_valid   <= 1'b0;
                    end
                end
                STAGE_DECODE: begin
                    opcode    <= instruction[6:0];
                    rd        <= instruction[11:7];
                    funct3    <= instruction[14:12];
                    rs1       <= instruction[19:15];
                    rs2       <= instruction[24:20];
                    funct7_b5 <= instruction[30];
                    case (instruction[6:0])
                        OPC_STORE:         imm <= {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
                        OPC_BRANCH:        imm <= {{19{instruction[31]}}, instruction[31], instruction[7],
                                                   instruction[30:25], instruction[11:8], 1'b0};
                        OPC_LUI, OPC_AUIPC: imm <= {instruction[31:12], 12'd0};
                        OPC_JAL:           imm <= {{11{instruction[31]}}, instruction[31], instruction[19:12],
                                                   instruction[20], instruction[30:21], 1'b0};
                        default:           imm <= {{20{instruction[31]}}, instruction[31:20]};
                    endcase
                end
                STAGE_ALU_PREPARE: begin
                    op_a <= x[rs1];
                    op_b <= x[rs2];
                end
                STAGE_EXECUTE: begin
                    alu_result   <= alu_comb;
                    branch_taken <= cmp_comb;
                    ea           <= op_a + imm;
                end
                STAGE_MEM: begin
                    if (led_store) begin
                        debug_led <= op_b[0];
                    end else if (!mem_valid) begin
                        mem_valid        <= 1'b1;
                        mem_addr         <= {ea[31:2], 2'b00};
                        mem_wen          <= is_store ? store_wen : 4'b0000;
                        mem_data_cpu_out <= store_data;
                    end else if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_wen   <= 4'b0000;
                        if (is_load) load_result <= load_comb;
                    end
                end
                STAGE_WRITEBACK: begin
                    if (writes_rd && (rd != 5'd0)) x[rd] <= rd_value;
                    if (opcode == OPC_JAL || (opcode == OPC_BRANCH && branch_taken))
                        pc <= pc + imm;
                    else if (opcode == OPC_JALR)
                        pc <= ea & ~32'd1;
                    else
                        pc <= pc + 32'd4;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_leiwand_rv32_core.sv
// tb/tb_leiwand_rv32_core.sv - scoreboard bench running a small RV32I program on the core and simple_mem
module tb_leiwand_rv32_core;
    import leiwand_rv32_constants::*;

    localparam logic [31:0] BASE        = 32'h2040_0000;
    localparam logic [31:0] DATA_ADDR   = 32'h2040_1000;
    localparam logic [31:0] SUCCESS_PC  = BASE + 32'd108;
    localparam int          PROG_WORDS  = 28;

    typedef struct {
        logic [31:0] pc;
        int          rd;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_data_cpu_in, mem_data_cpu_out;
    logic [3:0]  mem_wen;
    logic        debug_led;

    logic        mem_rst = 1'b1;
    logic        loading = 1'b1;
    logic        stall = 1'b0;
    logic        ld_valid = 1'b0;
    logic [3:0]  ld_wen = 4'b0000;
    logic [31:0] ld_addr = 32'd0;
    logic [31:0] ld_wdata = 32'd0;
    logic        m_valid, m_ready;
    logic [3:0]  m_wen;
    logic [31:0] m_addr, m_wdata;

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb_q[$];
    logic [31:0] prog [0:PROG_WORDS-1];
    logic        running = 1'b0;
    logic        done = 1'b0;
    logic        first_bus = 1'b1;
    logic        prev_valid = 1'b0;
    logic [2:0]  prev_stage = 3'd0;

    always #5 clk = ~clk;

    assign m_valid   = loading ? ld_valid : mem_valid;
    assign m_wen     = loading ? ld_wen   : mem_wen;
    assign m_addr    = loading ? ld_addr  : mem_addr;
    assign m_wdata   = loading ? ld_wdata : mem_data_cpu_out;
    assign mem_ready = m_ready & ~stall;

    leiwand_rv32_core dut (
        .clk              (clk),
        .reset            (reset),
        .mem_valid        (mem_valid),
        .mem_ready        (mem_ready),
        .mem_addr         (mem_addr),
        .mem_data_cpu_in  (mem_data_cpu_in),
        .mem_data_cpu_out (mem_data_cpu_out),
        .mem_wen          (mem_wen),
        .debug_led        (debug_led)
    );

    simple_mem #(.WORDS(4096)) u_mem (
        .clk   (clk),
        .rst   (mem_rst),
        .valid (m_valid),
        .ready (m_ready),
        .wen   (m_wen),
        .addr  (m_addr),
        .wdata (m_wdata),
        .rdata (mem_data_cpu_in)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] off, input int rd, input logic [31:0] val);
        exp_t e;
        e.pc  = BASE + off;
        e.rd  = rd;
        e.val = val;
        sb_q.push_back(e);
    endtask

    // pc check when an instruction reaches ALU_PREPARE, register check on retire, bus checks on request start
    always @(negedge clk) begin
        if (running && !done) begin
            if (dut.cpu_stage == 3'd2 && prev_stage != 3'd2) begin
                if (sb_q.size() > 0) check_eq("pc", dut.pc, sb_q[0].pc);
                else begin
                    check_eq("success_pc", dut.pc, SUCCESS_PC);
                    done = 1'b1;
                end
            end
            if (prev_stage == 3'd5 && dut.cpu_stage == 3'd0 && sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq($sformatf("x%0d@%08h", e.rd, e.pc), dut.x[e.rd], e.val);
            end
            if (dut.cpu_stage == 3'd4 && dut.pc == BASE + 32'd100)
                check_eq("led_store_no_valid", {31'd0, mem_valid}, 32'd0);
            if (mem_valid && !prev_valid) begin
                check_eq("addr_aligned", {30'd0, mem_addr[1:0]}, 32'd0);
                if (first_bus) begin
                    check_eq("first_addr", mem_addr, BASE);
                    check_eq("first_wen", {28'd0, mem_wen}, 32'd0);
                    first_bus = 1'b0;
                end
                if (dut.cpu_stage == 3'd0) check_eq("fetch_addr", mem_addr, dut.pc);
                if (dut.cpu_stage == 3'd4) begin
                    case (dut.pc - BASE)
                        32'd12: begin
                            check_eq("sw_addr", mem_addr, DATA_ADDR);
                            check_eq("sw_wen", {28'd0, mem_wen}, 32'hF);
                            check_eq("sw_data", mem_data_cpu_out, 32'd5);
                        end
                        32'd16: check_eq("lw_wen", {28'd0, mem_wen}, 32'd0);
                        32'd20: begin
                            check_eq("sb_addr", mem_addr, DATA_ADDR);
                            check_eq("sb_wen", {28'd0, mem_wen}, 32'h2);
                            check_eq("sb_data", mem_data_cpu_out, 32'h0505_0505);
                        end
                        32'd32: begin
                            check_eq("sb2_wen", {28'd0, mem_wen}, 32'h4);
                            check_eq("sb2_data", mem_data_cpu_out, 32'h8080_8080);
                        end
                        default: ;
                    endcase
                end
            end
        end
        prev_valid = mem_valid;
        prev_stage = dut.cpu_stage;
    end

    initial begin
        int cyc;
        for (int i = 0; i < PROG_WORDS; i++) prog[i] = 32'h0000_0013;
        prog[0]  = 32'h00500093;  // addi x1,x0,5
        prog[1]  = 32'h00100013;  // addi x0,x0,1
        prog[2]  = 32'h20401137;  // lui x2,0x20401
        prog[3]  = 32'h00112023;  // sw x1,0(x2)
        prog[4]  = 32'h00012183;  // lw x3,0(x2)
        prog[5]  = 32'h001100A3;  // sb x1,1(x2)
        prog[6]  = 32'h00012203;  // lw x4,0(x2)
        prog[7]  = 32'h08000293;  // addi x5,x0,0x80
        prog[8]  = 32'h00510123;  // sb x5,2(x2)
        prog[9]  = 32'h00210303;  // lb x6,2(x2)
        prog[10] = 32'h00214383;  // lbu x7,2(x2)
        prog[11] = 32'h00000463;  // beq x0,x0,+8
        prog[12] = 32'h06300093;  // addi x1,x0,99 (must be skipped)
        prog[13] = 32'h00001463;  // bne x0,x0,+8
        prog[14] = 32'h0100046F;  // jal x8,+16
        prog[15] = 32'h0015A633;  // slt x12,x11,x1
        prog[16] = 32'h0015B6B3;  // sltu x13,x11,x1
        prog[17] = 32'h0180006F;  // jal x0,+24
        prog[18] = 32'h800004B7;  // lui x9,0x80000
        prog[19] = 32'h4044D513;  // srai x10,x9,4
        prog[20] = 32'h401005B3;  // sub x11,x0,x1
        prog[21] = 32'h00040067;  // jalr x0,0(x8)
        prog[22] = 32'h06300093;  // addi x1,x0,99 (must be skipped)
        prog[23] = 32'h10012737;  // lui x14,0x10012
        prog[24] = 32'h00100793;  // addi x15,x0,1
        prog[25] = 32'h00F72023;  // sw x15,0(x14) -> LED
        prog[26] = 32'h00012803;  // lw x16,0(x2) (stalled)
        prog[27] = 32'h0000006F;  // jal x0,0

        push_exp(0,   1, 32'd5);
        push_exp(4,   0, 32'd0);
        push_exp(8,   2, DATA_ADDR);
        push_exp(12,  1, 32'd5);
        push_exp(16,  3, 32'd5);
        push_exp(20,  1, 32'd5);
        push_exp(24,  4, 32'h0000_0505);
        push_exp(28,  5, 32'h0000_0080);
        push_exp(32,  5, 32'h0000_0080);
        push_exp(36,  6, 32'hFFFF_FF80);
        push_exp(40,  7, 32'h0000_0080);
        push_exp(44,  1, 32'd5);
        push_exp(52,  0, 32'd0);
        push_exp(56,  8, BASE + 32'd60);
        push_exp(72,  9, 32'h8000_0000);
        push_exp(76, 10, 32'hF800_0000);
        push_exp(80, 11, 32'hFFFF_FFFB);
        push_exp(84,  0, 32'd0);
        push_exp(60, 12, 32'd1);
        push_exp(64, 13, 32'd0);
        push_exp(68,  0, 32'd0);
        push_exp(92, 14, 32'h1001_2000);
        push_exp(96, 15, 32'd1);
        push_exp(100, 15, 32'd1);
        push_exp(104, 16, 32'h0080_0505);

        repeat (2) @(negedge clk);
        mem_rst = 1'b0;
        for (int i = 0; i < PROG_WORDS; i++) begin
            ld_valid = 1'b1;
            ld_wen   = 4'b1111;
            ld_addr  = BASE + 32'(4 * i);
            ld_wdata = prog[i];
            @(negedge clk);
        end
        ld_valid = 1'b0;
        ld_wen   = 4'b0000;
        repeat (3) @(negedge clk);
        loading = 1'b0;
        @(negedge clk);

        check_eq("rst_stage", {29'd0, dut.cpu_stage}, 32'd0);
        check_eq("rst_pc", dut.pc, BASE);
        check_eq("rst_instr", dut.instruction, 32'd0);
        check_eq("rst_valid", {31'd0, mem_valid}, 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        check_eq("rst_led", {31'd0, debug_led}, 32'd0);
        check_eq("rst_x5", dut.x[5], 32'd0);

        reset   = 1'b0;
        running = 1'b1;

        cyc = 0;
        while (!(dut.cpu_stage == 3'd4 && dut.pc == BASE + 32'd104) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("reach_stall_point", {29'd0, dut.cpu_stage}, 32'd4);
        stall = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("stall_stage", {29'd0, dut.cpu_stage}, 32'd4);
        check_eq("stall_valid", {31'd0, mem_valid}, 32'd1);
        check_eq("stall_pc", dut.pc, BASE + 32'd104);
        stall = 1'b0;

        cyc = 0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("reach_success", {31'd0, done}, 32'd1);
        check_eq("sb_drained", sb_q.size(), 32'd0);
        check_eq("led_on", {31'd0, debug_led}, 32'd1);
        check_eq("x0_zero", dut.x[0], 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
